// File: rtl/simon_key_step.sv
// simon_key_step: one registered step of the Simon key schedule, k[i] from {k[i-1]..k[i-M]} and i
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   valid_in   key_in/round_idx valid this cycle
//   key_in     {k[i-1], ..., k[i-M]}, k[i-1] in the MSBs
//   round_idx  index i of the key to produce
//   key_out    registered k[i]
//   valid_out  key_out/idx_err valid (one cycle per accepted request)
//   idx_err    round_idx was outside M <= i < T for the last accepted request
module simon_key_step #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_in,
  input  logic [N*M-1:0] key_in,
  input  logic [7:0]     round_idx,
  output logic [N-1:0]   key_out,
  output logic           valid_out,
  output logic           idx_err
);
  // Leftmost character of each sequence is index 0, so z[j] lives at bit 61-j.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam bit LEGAL = (N == 16 && M == 4) || ((N == 24 || N == 32) && (M == 3 || M == 4)) ||
                         (N == 48 && (M == 2 || M == 3)) || (N == 64 && M >= 2 && M <= 4);
  localparam int T = N == 16 ? 32 : N == 24 ? 36 : N == 32 ? (M == 3 ? 42 : 44) :
                     N == 48 ? (M == 2 ? 52 : 54) : (M == 2 ? 68 : M == 3 ? 69 : 72);
  localparam logic [61:0] ZSEQ = (N == 16 || (N == 24 && M == 3)) ? Z0 : N == 24 ? Z1 :
                                 ((N == 32 && M == 3) || M == 2) ? Z2 : (M == 3 || N == 32) ? Z3 : Z4;
  localparam logic [N-1:0] C = {{(N-2){1'b1}}, 2'b00};
  if (!LEGAL) begin : g_bad_pair
    $error("simon_key_step: (N,M) is not a Simon parameter pair");
  end
  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction
  logic [N-1:0] k1, k3, km, t1, tmp, nxt;
  logic [7:0]   d;
  logic [5:0]   j;
  logic         z_bit, err;
  always_comb begin
    k1 = key_in[N*M-1 -: N];
    k3 = M == 4 ? key_in[2*N-1 -: N] : '0;
    km = key_in[N-1:0];
    t1 = ror(k1, 3) ^ k3;
    tmp = t1 ^ ror(t1, 1);
    // Out-of-range indices wrap as 8-bit unsigned before the mod-62 reduction.
    d = round_idx - 8'(M);
    j = 6'(d % 8'd62);
    z_bit = ZSEQ[6'd61 - j];
    nxt = C ^ km ^ tmp ^ {{(N-1){1'b0}}, z_bit};
    err = int'(round_idx) < M || int'(round_idx) >= T;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out <= '0;
      valid_out <= 1'b0;
      idx_err <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        key_out <= nxt;
        idx_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_simon_key_step.sv
// tb_simon_key_step: scoreboard bench for simon_key_step at (16,4) and (64,4)
module tb_simon_key_step;
  localparam string Z0 = "11111010001001010110000111001101111101000100101011000011100110";
  localparam string Z4 = "11010001111001101011011000100000010111000011001010010011101111";
  typedef struct {
    logic [63:0] k;
    logic        e;
    logic [7:0]  i;
    logic        rec;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic         v16 = 1'b0, v64 = 1'b0;
  logic [63:0]  k16 = '0;
  logic [255:0] k64 = '0;
  logic [7:0]   i16 = '0, i64 = '0;
  logic [15:0]  ko16;
  logic [63:0]  ko64;
  logic         vo16, vo64, e16, e64;
  simon_key_step #(.N(16), .M(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .valid_in(v16), .key_in(k16), .round_idx(i16),
    .key_out(ko16), .valid_out(vo16), .idx_err(e16)
  );
  simon_key_step #(.N(64), .M(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .valid_in(v64), .key_in(k64), .round_idx(i64),
    .key_out(ko64), .valid_out(vo64), .idx_err(e64)
  );
  exp_t q16[$], q64[$];
  logic [15:0] ks16[72];
  logic [63:0] ks64[72];
  logic [15:0] dk16[32];
  logic vexp16, vexp64;
  logic finish_req = 1'b0;
  int checks = 0, errors = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vexp16 <= 1'b0;
      vexp64 <= 1'b0;
    end else begin
      vexp16 <= v16;
      vexp64 <= v64;
    end
  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask = n == 64 ? '1 : (64'd1 << n) - 64'd1;
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction
  function automatic logic [63:0] ref_key(input int n, input int m, input int idx,
                                          input logic [63:0] w1, input logic [63:0] w3,
                                          input logic [63:0] wm, input string z);
    logic [63:0] mask = n == 64 ? '1 : (64'd1 << n) - 64'd1;
    int j = ((idx - m) & 255) % 62;
    logic [63:0] t = rotr(w1, 3, n);
    if (m == 4) t = t ^ w3;
    t = t ^ rotr(t, 1, n);
    return (mask ^ 64'd3) ^ wm ^ t ^ {63'd0, z[j] == "1"};
  endfunction
  function automatic logic [31:0] simon32_enc(input logic [15:0] ks[32], input logic [31:0] pt);
    logic [15:0] x = pt[31:16], y = pt[15:0], t;
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ ks[r];
      y = t;
    end
    return {x, y};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic issue16(input logic [63:0] key, input logic [7:0] idx, input logic [15:0] ek,
                         input logic ee, input logic rec);
    @(posedge clk);
    #1;
    v16 = 1'b1;
    k16 = key;
    i16 = idx;
    q16.push_back('{{48'd0, ek}, ee, idx, rec});
  endtask
  task automatic issue64(input logic [255:0] key, input logic [7:0] idx, input logic [63:0] ek,
                         input logic ee);
    @(posedge clk);
    #1;
    v64 = 1'b1;
    k64 = key;
    i64 = idx;
    q64.push_back('{ek, ee, idx, 1'b0});
  endtask
  task automatic idle;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    v64 = 1'b0;
  endtask
  initial begin
    logic [15:0] last16;
    logic [63:0] last64;
    exp_t e;
    last16 = '0;
    last64 = '0;
    dk16[0] = 16'h0100;
    dk16[1] = 16'h0908;
    dk16[2] = 16'h1110;
    dk16[3] = 16'h1918;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("reset_key16", ko16, 0);
        chk("reset_valid16", vo16, 0);
        chk("reset_err16", e16, 0);
        chk("reset_key64", ko64, 0);
        chk("reset_valid64", vo64, 0);
        q16.delete();
        q64.delete();
        last16 = '0;
        last64 = '0;
      end else if (finish_req) begin
        chk("drain16", q16.size(), 0);
        chk("drain64", q64.size(), 0);
        chk("simon32_ciphertext", simon32_enc(dk16, 32'h65656877), 32'hC69BE9BB);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end else begin
        chk("valid16", vo16, vexp16);
        if (vo16) begin
          if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra16: got key %h with no request outstanding", ko16);
          end else begin
            e = q16.pop_front();
            chk($sformatf("key16[%0d]", e.i), ko16, e.k);
            chk($sformatf("err16[%0d]", e.i), e16, e.e);
            if (e.rec) dk16[e.i[4:0]] = ko16;
            last16 = ko16;
          end
        end else chk("hold16", ko16, last16);
        chk("valid64", vo64, vexp64);
        if (vo64) begin
          if (q64.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra64: got key %h with no request outstanding", ko64);
          end else begin
            e = q64.pop_front();
            chk($sformatf("key64[%0d]", e.i), ko64, e.k);
            chk($sformatf("err64[%0d]", e.i), e64, e.e);
            last64 = ko64;
          end
        end else chk("hold64", ko64, last64);
      end
    end
  end
  initial begin
    logic [63:0] rk, r;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    issue16(64'h1918111009080100, 8'd4, 16'h71C3, 1'b0, 1'b1);
    issue16(64'h71C3191811100908, 8'd5, 16'hB649, 1'b0, 1'b1);
    idle();
    ks16[0] = 16'h0100;
    ks16[1] = 16'h0908;
    ks16[2] = 16'h1110;
    ks16[3] = 16'h1918;
    for (int i = 4; i < 32; i++) begin
      ks16[i] = 16'(ref_key(16, 4, i, 64'(ks16[i-1]), 64'(ks16[i-3]), 64'(ks16[i-4]), Z0));
      issue16({ks16[i-1], ks16[i-2], ks16[i-3], ks16[i-4]}, 8'(i), ks16[i], 1'b0, 1'b1);
      if ($urandom_range(3) == 0) idle();
    end
    idle();
    foreach (ks16[i]) if (i >= 32) ks16[i] = 16'($urandom);
    rk = {$urandom, $urandom};
    issue16(rk, 8'd3, 16'(ref_key(16, 4, 3, 64'(rk[63:48]), 64'(rk[31:16]), 64'(rk[15:0]), Z0)), 1'b1, 1'b0);
    rk = {$urandom, $urandom};
    issue16(rk, 8'd32, 16'(ref_key(16, 4, 32, 64'(rk[63:48]), 64'(rk[31:16]), 64'(rk[15:0]), Z0)), 1'b1, 1'b0);
    rk = {$urandom, $urandom};
    issue16(rk, 8'd31, 16'(ref_key(16, 4, 31, 64'(rk[63:48]), 64'(rk[31:16]), 64'(rk[15:0]), Z0)), 1'b0, 1'b0);
    idle();
    repeat (2) idle();
    issue16({$urandom, $urandom}, 8'd10, 16'h0, 1'b0, 1'b0);
    issue16({$urandom, $urandom}, 8'd11, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 v16 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    rk = {$urandom, $urandom};
    issue16(rk, 8'd7, 16'(ref_key(16, 4, 7, 64'(rk[63:48]), 64'(rk[31:16]), 64'(rk[15:0]), Z0)), 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) ks64[i] = {$urandom, $urandom};
    for (int i = 4; i < 72; i++) begin
      ks64[i] = ref_key(64, 4, i, ks64[i-1], ks64[i-3], ks64[i-4], Z4);
      issue64({ks64[i-1], ks64[i-2], ks64[i-3], ks64[i-4]}, 8'(i), ks64[i], 1'b0);
      if ($urandom_range(3) == 0) idle();
    end
    idle();
    foreach (ks64[i]) if (i < 4) r = ks64[i];
    for (int n = 0; n < 4; n++) begin
      logic [7:0] idx;
      logic [255:0] kk;
      idx = n == 0 ? 8'd72 : n == 1 ? 8'd255 : n == 2 ? 8'd3 : 8'd71;
      kk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      issue64(kk, idx, ref_key(64, 4, int'(idx), kk[255:192], kk[127:64], kk[63:0], Z4), n != 3);
    end
    repeat (3) idle();
    finish_req = 1'b1;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
endmodule
